st_packet_arbiter: RTL and testbench

//  Round-robin, packet-locked arbiter that shares one Avalon-ST 32-bit packet sink between NUM_INPUTS sources.

---
 rtl/st_packet_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_st_packet_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// st_packet_arbiter
//
// Round-robin, packet-locked arbiter that shares one Avalon-ST packet sink
// between NUM_INPUTS sources (DMA and test-pattern generators feeding the FFT
// input timing adapter). A grant is taken at the first beat of a packet and
// held until its EOP beat is accepted, so packets are never interleaved.
// The output stage is a single register: ready latency 0 on every port.
//
// Parameters
//   NUM_INPUTS  number of sources, 2..4
//   DATA_W      data width in bits (EMPTY_W = log2(DATA_W/8))
//
// Ports
//   clk                rising-edge clock
//   reset_n            asynchronous active-low reset
//   in_valid/in_ready  per-source handshake (one bit per source)
//   in_data            packed payload, source i at [i*DATA_W +: DATA_W]
//   in_startofpacket   per-source SOP
//   in_endofpacket     per-source EOP
//   in_empty           packed empty, source i at [i*EMPTY_W +: EMPTY_W]
//   out_ready          sink ready
//   out_valid/out_*    registered output beat
//   err_nosop          1-cycle pulse, aligned with out_valid rising, when the
//                      first beat of a grant arrived without SOP
//   out_channel        grant index of the output beat (only with the option)
//
// Build option
//   ST_ARB_CHANNEL_EN  when defined, adds out_channel carrying the source index
//                      of each beat, registered together with the payload.
// -----------------------------------------------------------------------------
module st_packet_arbiter #(
  parameter int  NUM_INPUTS = 2,
  parameter int  DATA_W     = 32,
  localparam int EMPTY_W    = $clog2(DATA_W / 8),
  localparam int GW         = $clog2(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_INPUTS-1:0]        in_valid,
  output logic [NUM_INPUTS-1:0]        in_ready,
  input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]        in_startofpacket,
  input  logic [NUM_INPUTS-1:0]        in_endofpacket,
  input  logic [NUM_INPUTS*EMPTY_W-1:0] in_empty,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_startofpacket,
  output logic                         out_endofpacket,
  output logic [EMPTY_W-1:0]           out_empty,
  output logic                         err_nosop
`ifdef ST_ARB_CHANNEL_EN
  ,
  output logic [GW-1:0]                out_channel
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Reset value of last_grant makes source 0 the first winner.
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_INPUTS - 1);

  state_t              state, state_nxt;
  logic [GW-1:0]       grant, grant_nxt;
  logic [GW-1:0]       last_grant, last_grant_nxt;
  logic                first_beat, first_beat_nxt;
  logic                accept;

  logic [DATA_W-1:0]   data_p0;
  logic                sop_p0;
  logic                eop_p0;
  logic [EMPTY_W-1:0]  empty_p0;
  logic                vld_p0;

  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                sop_p1;
  logic                eop_p1;
  logic [EMPTY_W-1:0]  empty_p1;
  logic                err_p1;

  // First requesting source after 'last', scanning last+1, last+2, ...
  // wrapping modulo NUM_INPUTS. 'last' itself is scanned last.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                            input logic [GW-1:0]         last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = (int'(last) + k) % NUM_INPUTS;
      if (!found && req[idx]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Stage p0: payload of the granted source, combinational select
  assign data_p0  = in_data[grant*DATA_W +: DATA_W];
  assign sop_p0   = in_startofpacket[grant];
  assign eop_p0   = in_endofpacket[grant];
  assign empty_p0 = in_empty[grant*EMPTY_W +: EMPTY_W];
  assign vld_p0   = accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
      first_beat <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      first_beat <= first_beat_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    first_beat_nxt = first_beat;
    in_ready       = '0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        // One arbitration cycle per packet; no source is ready here.
        if (|in_valid) begin
          grant_nxt      = rr_pick(in_valid, last_grant);
          first_beat_nxt = 1'b1;
          state_nxt      = LOCKED;
        end
      end
      LOCKED: begin
        // Ready only when the output register is empty or draining this cycle.
        in_ready[grant] = !vld_p1 || out_ready;
        accept          = in_valid[grant] && (!vld_p1 || out_ready);
        if (accept) begin
          first_beat_nxt = 1'b0;
          if (eop_p0) begin
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      sop_p1   <= 1'b0;
      eop_p1   <= 1'b0;
      empty_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      if (vld_p0) begin
        vld_p1   <= 1'b1;
        data_p1  <= data_p0;
        sop_p1   <= sop_p0;
        eop_p1   <= eop_p0;
        empty_p1 <= empty_p0;
      end else if (out_ready) begin
        vld_p1   <= 1'b0;
      end
      // Single-cycle flag, raised with the beat that opened the grant without SOP.
      err_p1 <= vld_p0 && first_beat && !sop_p0;
    end
  end

  assign out_valid         = vld_p1;
  assign out_data          = data_p1;
  assign out_startofpacket = sop_p1;
  assign out_endofpacket   = eop_p1;
  assign out_empty         = empty_p1;
  assign err_nosop         = err_p1;

`ifdef ST_ARB_CHANNEL_EN
  logic [GW-1:0] chan_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_p1 <= '0;
    end else if (vld_p0) begin
      chan_p1 <= grant;
    end
  end

  assign out_channel = chan_p1;
`endif

endmodule

// File: tb/tb_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_st_packet_arbiter
//
// Self-checking bench for st_packet_arbiter (NUM_INPUTS=2, DATA_W=32).
// Packets are described per source; the expected output stream is built from
// the round-robin packet order (one whole packet per grant, rotating from the
// source after the last one served) and compared beat by beat.
// -----------------------------------------------------------------------------
module tb_st_packet_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        first;
    logic        err;
  } beat_t;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_sop;
  logic [N-1:0]    in_eop;
  logic [N*2-1:0]  in_empty;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [1:0]      out_empty;
  logic            err_nosop;
`ifdef ST_ARB_CHANNEL_EN
  logic [0:0]      out_channel;
`endif

  st_packet_arbiter #(.NUM_INPUTS(N), .DATA_W(DW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty),
    .err_nosop         (err_nosop)
`ifdef ST_ARB_CHANNEL_EN
    ,
    .out_channel       (out_channel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t src_q[N][$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  int    hold_viol, stall_viol, multi_ready, err_cycles;
  bit    timeout;
  int    rr_last;

  task automatic clear_model();
    for (int s = 0; s < N; s++) src_q[s].delete();
    exp_q.delete();
  endtask

  // Appends one packet to source s and to the expected stream (call in grant order).
  task automatic gen_packet(input int s, input int len, input logic [31:0] base,
                            input bit nosop, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = rnd ? $urandom : base + i;
      b.sop   = (i == 0) && !nosop;
      b.eop   = (i == len - 1);
      b.empty = (rnd && i == len - 1) ? 2'($urandom_range(0, 3)) : 2'd0;
      b.first = (i == 0);
      b.err   = 1'b0;
      src_q[s].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // Drives all source queues and records every output handshake.
  task automatic run_engine(input int max_cycles, input int ready_pct, input int bubble_pct,
                            input logic [63:0] script, input bit scripted);
    int            total;
    int            ptr[N];
    logic [N-1:0]  acc;
    bit            prev_acc, prev_hold, v;
    logic          pend_err;
    logic [DW-1:0] prev_data;
    beat_t         b, o;
    total = 0;
    for (int s = 0; s < N; s++) begin
      total += src_q[s].size();
      ptr[s] = 0;
    end
    obs_q.delete();
    obs_cyc.delete();
    hold_viol = 0; stall_viol = 0; multi_ready = 0; err_cycles = 0;
    prev_acc = 0; prev_hold = 0; pend_err = 1'b0; prev_data = '0;
    for (int c = 0; c < max_cycles && obs_q.size() < total; c++) begin
      for (int s = 0; s < N; s++) begin
        if (ptr[s] < src_q[s].size()) begin
          b = src_q[s][ptr[s]];
          v = b.first || ($urandom_range(0, 99) >= bubble_pct);
        end else begin
          b = '0;
          v = 0;
        end
        in_valid[s]         = v;
        in_data[s*DW +: DW] = v ? b.data : $urandom;
        in_sop[s]           = v ? b.sop : 1'($urandom_range(0, 1));
        in_eop[s]           = v ? b.eop : 1'($urandom_range(0, 1));
        in_empty[s*2 +: 2]  = b.empty;
      end
      out_ready = scripted ? ((c < 64) ? script[c] : 1'b1)
                           : ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if ($countones(in_ready) > 1) multi_ready++;
      if (prev_hold && (!out_valid || out_data !== prev_data)) hold_viol++;
      if (out_valid && !out_ready && in_ready !== '0) stall_viol++;
      if (prev_acc) pend_err = err_nosop;
      if (err_nosop) err_cycles++;
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
        o.data = out_data; o.sop = out_sop; o.eop = out_eop; o.empty = out_empty;
        o.first = 1'b0; o.err = pend_err;
        obs_q.push_back(o);
        obs_cyc.push_back(c);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      @(posedge clk); #1;
      for (int s = 0; s < N; s++) if (acc[s]) ptr[s]++;
      prev_acc = |acc;
    end
    timeout   = (obs_q.size() < total);
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 2'b11; in_data = '0; in_sop = 2'b11; in_eop = '0;
    in_empty = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL reset in_ready: got %b, required 00", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
    checks++; if (err_nosop !== 1'b0) begin errors++; $display("FAIL reset err_nosop: got %b, required 0", err_nosop); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h, required 0", out_data); end
    in_valid = '0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    rr_last = N - 1;
  endtask

  task automatic test_two_packets();
    int gap_exp[5] = '{1, 1, 2, 1, 1};
    clear_model();
    gen_packet(0, 3, 32'hA0, 0, 0);
    gen_packet(1, 3, 32'hB0, 0, 0);
    run_engine(60, 100, 0, '0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL two_packets count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].err} !==
          {exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].first && !exp_q[i].sop}) begin
        errors++;
        $display("FAIL two_packets beat %0d: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                 i, obs_q[i].data, obs_q[i].sop, obs_q[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
      end
    end
    if (obs_cyc.size() == 6) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_cyc[i+1] - obs_cyc[i] != gap_exp[i]) begin
          errors++;
          $display("FAIL two_packets spacing %0d: got %0d cycles, required %0d", i, obs_cyc[i+1] - obs_cyc[i], gap_exp[i]);
        end
      end
    end
    rr_last = 1;
  endtask

  task automatic test_single_beat();
    in_valid = 2'b10; in_data = {32'h1234, 32'h0}; in_sop = 2'b10; in_eop = 2'b10;
    in_empty = '0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL single_beat cycle1 in_ready: got %b, required 00", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (in_ready !== 2'b10) begin errors++; $display("FAIL single_beat cycle2 in_ready: got %b, required 10", in_ready); end
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_beat cycle3 out_valid: got %b, required 1", out_valid); end
    checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL single_beat cycle3 out_data: got %h, required 00001234", out_data); end
    checks++; if ({out_sop, out_eop} !== 2'b11) begin errors++; $display("FAIL single_beat cycle3 sop/eop: got %b, required 11", {out_sop, out_eop}); end
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL single_beat cycle3 in_ready: got %b, required 00", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_beat cycle4 out_valid: got %b, required 0", out_valid); end
    @(posedge clk); #1;
    rr_last = 1;
  endtask

  task automatic test_backpressure();
    clear_model();
    gen_packet(0, 4, 32'hC0, 0, 0);
    // out_ready low for cycles 3..7 while the second beat sits in the output register
    run_engine(60, 100, 0, 64'hFFFF_FFFF_FFFF_FF07, 1);
    checks++; if (timeout) begin errors++; $display("FAIL backpressure count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL backpressure beats: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].sop, obs_q[i].eop} !== {exp_q[i].data, exp_q[i].sop, exp_q[i].eop}) begin
        errors++;
        $display("FAIL backpressure beat %0d: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                 i, obs_q[i].data, obs_q[i].sop, obs_q[i].eop, exp_q[i].data, exp_q[i].sop, exp_q[i].eop);
      end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL backpressure in_ready during stall: got %0d cycles high, required 0", stall_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL backpressure hold: got %0d unstable cycles, required 0", hold_viol); end
    if (obs_cyc.size() >= 2) begin
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != 6) begin
        errors++;
        $display("FAIL backpressure stall length: got %0d cycles between beats, required 6", obs_cyc[1] - obs_cyc[0]);
      end
    end
    rr_last = 0;
  endtask

  task automatic test_nosop();
    clear_model();
    gen_packet(0, 2, 32'h55, 1, 0);
    // stall the first beat for two cycles: the error flag must still last one cycle
    run_engine(60, 100, 0, 64'hFFFF_FFFF_FFFF_FFF3, 1);
    checks++; if (timeout) begin errors++; $display("FAIL nosop count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].err} !==
          {exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].first && !exp_q[i].sop}) begin
        errors++;
        $display("FAIL nosop beat %0d: got data=%h sop=%b eop=%b err=%b, required data=%h sop=%b eop=%b err=%b",
                 i, obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].err,
                 exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].first && !exp_q[i].sop);
      end
    end
    checks++; if (err_cycles != 1) begin errors++; $display("FAIL nosop pulse width: got %0d cycles, required 1", err_cycles); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL nosop hold: got %0d unstable cycles, required 0", hold_viol); end
    rr_last = 0;
  endtask

  task automatic test_random();
    int ready_pct[2]  = '{70, 100};
    int bubble_pct[2] = '{25, 0};
    int s, exp_err;
    for (int pass = 0; pass < 2; pass++) begin
      clear_model();
      for (int p = 0; p < 8; p++) begin
        for (int k = 0; k < N; k++) begin
          s = (rr_last + 1 + k) % N;
          gen_packet(s, $urandom_range(1, 4), 32'h0, ($urandom_range(0, 7) == 0), 1);
        end
      end
      rr_last = s;
      exp_err = 0;
      foreach (exp_q[i]) if (exp_q[i].first && !exp_q[i].sop) exp_err++;
      run_engine(3000, ready_pct[pass], bubble_pct[pass], '0, 0);
      checks++; if (timeout) begin errors++; $display("FAIL random%0d count: got %0d beats, required %0d", pass, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if ({obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].err} !==
            {exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].first && !exp_q[i].sop}) begin
          errors++;
          $display("FAIL random%0d beat %0d: got data=%h sop=%b eop=%b empty=%0d err=%b, required data=%h sop=%b eop=%b empty=%0d err=%b",
                   pass, i, obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].err,
                   exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].first && !exp_q[i].sop);
        end
      end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL random%0d hold: got %0d, required 0", pass, hold_viol); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL random%0d stall ready: got %0d, required 0", pass, stall_viol); end
      checks++; if (multi_ready != 0) begin errors++; $display("FAIL random%0d multiple ready: got %0d, required 0", pass, multi_ready); end
      checks++; if (err_cycles != exp_err) begin errors++; $display("FAIL random%0d err pulses: got %0d, required %0d", pass, err_cycles, exp_err); end
    end
  endtask

  task automatic test_midreset();
    int   k;
    bit   acc1, seen;
    logic [31:0] first_data;
    // serve source 0 once so that, without a reset, source 1 would win next
    clear_model();
    gen_packet(0, 1, 32'hE00, 0, 0);
    run_engine(50, 100, 0, '0, 0);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midreset warmup: got %0d beats, required 1", obs_q.size()); end
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      in_valid = 2'b10;
      in_data[DW +: DW] = 32'hD0 + k;
      in_sop = {1'(k == 0), 1'b0};
      in_eop = 2'b00;
      @(negedge clk);
      acc1 = in_valid[1] && in_ready[1];
      @(posedge clk); #1;
      if (acc1) k++;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL midreset progress: got %0d beats accepted, required 2", k); end
    in_data[DW +: DW] = 32'hD2;
    in_sop = 2'b00;
    @(negedge clk) reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL midreset in_ready: got %b, required 00", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midreset out_data: got %h, required 0", out_data); end
    checks++; if (err_nosop !== 1'b0) begin errors++; $display("FAIL midreset err_nosop: got %b, required 0", err_nosop); end
    in_valid = 2'b11;
    in_data[0 +: DW] = 32'hE1;
    in_sop = 2'b01;
    in_eop = 2'b01;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    first_data = '0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        first_data = out_data;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL midreset regrant: got no output in 10 cycles, required a beat"); end
    checks++; if (first_data !== 32'hE1) begin errors++; $display("FAIL midreset first winner: got data=%h, required 000000e1 (source 0)", first_data); end
    in_valid = '0;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_two_packets();
    test_single_beat();
    test_backpressure();
    test_nosop();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
